block_check_sched: RTL and testbench

BLOCK_CHECK_SCHED -- requirements
Module: block_check_sched

---
 rtl/block_check_sched.sv | 158 +++++++++++++++
 tb/tb_block_check_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/block_check_sched.sv
// Four-stream round-robin scheduler that checks " begin"/" end" keyword balance per stream.
// Optional per-stream context clear is enabled by defining BLOCK_SCHED_CLR_EN.
module block_check_sched #(
    parameter int DEPTH_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] in,
`ifdef BLOCK_SCHED_CLR_EN
    input  logic [3:0]  clr,
`endif
    output logic [3:0]  ack,
    output logic [1:0]  grant_id,
    output logic [3:0]  result
);

    // Handshake: a stream holds req[i] and its in byte until ack[i]; ack is combinational
    // and the byte is consumed at the rising edge where req[i] && ack[i].
    localparam logic signed [DEPTH_W-1:0] DEPTH_MAX = {1'b0, {(DEPTH_W-1){1'b1}}};
    localparam logic signed [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};
    localparam logic [55:0] HIST_RST   = {7{8'h20}};
    localparam logic [55:0] BEGIN_MASK = {8'h00, {6{8'hff}}};
    localparam logic [55:0] BEGIN_PAT  = {8'h00, 48'h20_62_65_67_69_6e};
    localparam logic [55:0] END_MASK   = {24'h000000, {4{8'hff}}};
    localparam logic [55:0] END_PAT    = {24'h000000, 32'h20_65_6e_64};

    logic [55:0]               hist_q  [4];
    logic [55:0]               hist_d  [4];
    logic signed [DEPTH_W-1:0] depth_q [4];
    logic signed [DEPTH_W-1:0] depth_d [4];
    logic [3:0]                pend_q, pend_d, dir_q, dir_d, err_q, err_d;
    logic [1:0]                rr_q, rr_d, gid_q, gid_d;
    logic [3:0]                clr_eff;

    logic                      found;
    logic [1:0]                grant;
    logic [7:0]                g_byte;
    logic                      g_delim;
    logic [55:0]               g_hist;
    logic signed [DEPTH_W-1:0] g_depth;
    logic                      g_pend, g_dir, g_err;

`ifdef BLOCK_SCHED_CLR_EN
    assign clr_eff = clr;
`else
    assign clr_eff = 4'b0000;
`endif

    always_comb begin
        found = 1'b0;
        grant = rr_q;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[rr_q + 2'(k)]) begin
                found = 1'b1;
                grant = rr_q + 2'(k);
            end
        end
        ack = (found && !reset) ? (4'b0001 << grant) : 4'b0000;
    end

    // Next context of the granted stream: resolve any pending step, then look for a new keyword.
    always_comb begin
        g_byte  = in[{grant, 3'b000} +: 8] | 8'h20;
        g_delim = (g_byte == 8'h20);
        g_hist  = {hist_q[grant][47:0], g_byte};
        g_depth = depth_q[grant];
        g_pend  = pend_q[grant];
        g_dir   = dir_q[grant];
        g_err   = err_q[grant];
        if (!err_q[grant]) begin
            if (pend_q[grant]) begin
                g_pend = 1'b0;
                if (g_delim) begin
                    if (g_depth[DEPTH_W-1]) g_err = 1'b1;
                end else begin
                    g_depth = g_dir ? g_depth - DEPTH_ONE : g_depth + DEPTH_ONE;
                end
            end
            if ((g_hist & BEGIN_MASK) == BEGIN_PAT) begin
                if (g_depth == DEPTH_MAX) begin
                    g_err = 1'b1;
                end else begin
                    g_depth = g_depth + DEPTH_ONE;
                    g_pend  = 1'b1;
                    g_dir   = 1'b1;
                end
            end else if ((g_hist & END_MASK) == END_PAT) begin
                g_depth = g_depth - DEPTH_ONE;
                g_pend  = 1'b1;
                g_dir   = 1'b0;
            end
        end
    end

    always_comb begin
        rr_d  = rr_q;
        gid_d = gid_q;
        if (|ack) begin
            rr_d  = grant;
            gid_d = grant;
        end
        pend_d = pend_q;
        dir_d  = dir_q;
        err_d  = err_q;
        for (int i = 0; i < 4; i++) begin
            hist_d[i]  = hist_q[i];
            depth_d[i] = depth_q[i];
            if (ack[i]) begin
                hist_d[i]  = g_hist;
                depth_d[i] = g_depth;
                pend_d[i]  = g_pend;
                dir_d[i]   = g_dir;
                err_d[i]   = g_err;
            end
            // A clear overrides a byte consumed in the same cycle; the byte is dropped.
            if (clr_eff[i]) begin
                hist_d[i]  = HIST_RST;
                depth_d[i] = '0;
                pend_d[i]  = 1'b0;
                dir_d[i]   = 1'b0;
                err_d[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i]  <= HIST_RST;
                depth_q[i] <= '0;
            end
            pend_q <= '0;
            dir_q  <= '0;
            err_q  <= '0;
            rr_q   <= 2'd3;
            gid_q  <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i]  <= hist_d[i];
                depth_q[i] <= depth_d[i];
            end
            pend_q <= pend_d;
            dir_q  <= dir_d;
            err_q  <= err_d;
            rr_q   <= rr_d;
            gid_q  <= gid_d;
        end
    end

    always_comb begin
        grant_id = reset ? 2'd0 : ((|ack) ? grant : gid_q);
        for (int i = 0; i < 4; i++) begin
            result[i] = reset || ((depth_q[i] == '0) && !err_q[i]);
        end
    end

endmodule

// File: tb/tb_block_check_sched.sv
// Self-checking bench for block_check_sched: keyword balance, revert, error, saturation,
// round-robin order, reset mid-stream and (with BLOCK_SCHED_CLR_EN) per-stream clear.
module tb_block_check_sched;

    localparam int DW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] in;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic [3:0]  result;
`ifdef BLOCK_SCHED_CLR_EN
    logic [3:0]  clr;
`endif

    int          total = 0;
    int          bad = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_res;
    string       sat_exp;

    block_check_sched #(.DEPTH_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .in       (in),
`ifdef BLOCK_SCHED_CLR_EN
        .clr      (clr),
`endif
        .ack      (ack),
        .grant_id (grant_id),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one byte on stream s, wait (bounded) for its ack, then check result next cycle.
    task automatic send_byte(input int s, input logic [7:0] ch, input logic exp_r);
        int n = 0;
        @(negedge clk);
        req[s] = 1'b1;
        in[8*s +: 8] = ch;
        #1;
        while (!ack[s] && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("ack_onehot", 32'(ack), 32'(4'b0001 << s));
        exp_res[s] = exp_r;
        exp_q.push_back(exp_res);
        @(posedge clk);
        #1;
        req[s] = 1'b0;
        check_eq("result", 32'(result), 32'(exp_q.pop_front()));
    endtask

    task automatic send_str(input int s, input string str, input string exp);
        for (int i = 0; i < str.len(); i++) begin
            send_byte(s, str[i], exp[i] == 8'h31);
        end
    endtask

    initial begin
        reset   = 1'b1;
        req     = 4'b0000;
        in      = 32'h20202020;
        exp_res = 4'hF;
`ifdef BLOCK_SCHED_CLR_EN
        clr     = 4'b0000;
`endif
        #1;
        check_eq("rst_result", 32'(result), 32'hF);
        check_eq("rst_ack", 32'(ack), 32'h0);
        check_eq("rst_gid", 32'(grant_id), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("post_rst_result", 32'(result), 32'hF);
        check_eq("post_rst_gid", 32'(grant_id), 32'h0);

        send_str(0, "begin end ", "1111000011");
        send_str(1, " beginx", "1111101");
        send_str(2, " end ", "11100");
        send_str(2, " begin ", "0000000");
        check_eq("vec_after_err", 32'(result), 32'hB);

        // Fourth begin hits +3 with DEPTH_W=3: err sticks, so the three ends cannot rebalance.
        sat_exp = "11111";
        repeat (32) sat_exp = {sat_exp, "0"};
        send_str(1, " begin begin begin begin end end end ", sat_exp);
        check_eq("vec_after_sat", 32'(result), 32'h9);

        // Reset with all streams requesting: no ack, gated outputs.
        @(negedge clk);
        reset = 1'b1;
        req   = 4'hF;
        in    = 32'h20202020;
        #1;
        check_eq("rst2_ack", 32'(ack), 32'h0);
        check_eq("rst2_gid", 32'(grant_id), 32'h0);
        check_eq("rst2_result", 32'(result), 32'hF);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_res = 4'hF;
        check_eq("rst2_result_after", 32'(result), 32'hF);

        for (int i = 0; i < 8; i++) exp_q.push_back(4'b0001 << (i % 4));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("rr_ack", 32'(ack), 32'(exp_q.pop_front()));
            check_eq("rr_gid", 32'(grant_id), 32'(i % 4));
        end
        @(posedge clk);
        #1;
        req = 4'b0000;
        check_eq("rr_result", 32'(result), 32'hF);
        @(negedge clk);
        check_eq("gid_hold", 32'(grant_id), 32'h3);

        send_str(3, " begi", "11111");
        @(negedge clk);
        req[3]    = 1'b1;
        in[31:24] = "n";
        reset     = 1'b1;
        #1;
        check_eq("midrst_ack", 32'(ack), 32'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        req[3] = 1'b0;
        check_eq("midrst_result", 32'(result), 32'hF);
        check_eq("midrst_gid", 32'(grant_id), 32'h0);
        exp_res = 4'hF;
        send_str(3, "n ", "11");

`ifdef BLOCK_SCHED_CLR_EN
        send_str(0, " begin begin ", "1111100000000");
        @(negedge clk);
        clr[0]   = 1'b1;
        req[0]   = 1'b1;
        in[7:0]  = "x";
        #1;
        check_eq("clr_ack", 32'(ack), 32'h1);
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        req[0] = 1'b0;
        check_eq("clr_result", 32'(result), 32'hF);
        exp_res = 4'hF;
        send_str(0, "end ", "1100");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
